// File: rtl/hd44780_read_operation.sv
// hd44780_read_operation: read-side bus master for an HD44780/ST7066 LCD.
// Optional macro HD44780_READ_SYNC_EN adds a 2-flop synchronizer on i_d.
module hd44780_read_operation #(
    parameter int T_AS_CYC  = 4,
    parameter int T_PW_CYC  = 48,
    parameter int T_H_CYC   = 2,
    parameter int T_REC_CYC = 50,
    parameter int POLL_MAX  = 1024
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_ena,
    input  logic       i_start,
    input  logic       i_rs,
    input  logic       i_poll,
    input  logic [7:0] i_d,
    output logic       o_rs,
    output logic       o_rw,
    output logic       o_e,
    output logic       o_d_oe,
    output logic [7:0] o_q,
    output logic       o_bf,
    output logic [6:0] o_ac,
    output logic       o_valid,
    output logic       o_busy,
    output logic       o_timeout
);

`ifdef HD44780_READ_SYNC_EN
    localparam int PW_LEN = T_PW_CYC + 2;
`else
    localparam int PW_LEN = T_PW_CYC;
`endif
    localparam int MAX_A = (T_AS_CYC > T_H_CYC) ? T_AS_CYC : T_H_CYC;
    localparam int MAX_B = (PW_LEN > T_REC_CYC) ? PW_LEN : T_REC_CYC;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] AS_LAST  = CW'(T_AS_CYC - 1);
    localparam logic [CW-1:0] PW_LAST  = CW'(PW_LEN - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(T_H_CYC - 1);
    localparam logic [CW-1:0] REC_LAST = CW'(T_REC_CYC - 1);
    localparam logic [15:0]   POLL_LIM = 16'(POLL_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_E_HIGH,
        S_HOLD,
        S_RECOVER
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   poll_cnt_q, poll_cnt_d;
    logic          pend_q, pend_d;
    logic          rs_q, rs_d;
    logic          poll_q, poll_d;
    logic [7:0]    q_q, q_d;
    logic          bf_q, bf_d;
    logic [6:0]    ac_q, ac_d;
    logic          valid_q, valid_d;
    logic          timeout_q, timeout_d;
    logic          busy_q, busy_d;
    logic          e_q, e_d;
    logic          rw_q, rw_d;
    logic          rso_q, rso_d;
    logic          oe_q, oe_d;
    logic [7:0]    d_smp;

`ifdef HD44780_READ_SYNC_EN
    logic [7:0] sync1_q, sync2_q;

    // Two-stage synchronizer for the asynchronous panel data bus
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else if (i_ena) begin
            sync1_q <= i_d;
            sync2_q <= sync1_q;
        end
    end

    assign d_smp = sync2_q;
`else
    assign d_smp = i_d;
`endif

    // Sequencer: next state, phase counter, sampled data and bus outputs
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        poll_cnt_d = poll_cnt_q;
        pend_d     = pend_q;
        rs_d       = rs_q;
        poll_d     = poll_q;
        q_d        = q_q;
        bf_d       = bf_q;
        ac_d       = ac_q;
        valid_d    = 1'b0;
        timeout_d  = timeout_q;
        unique case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    pend_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_SETUP;
                end else if (i_start) begin
                    pend_d     = 1'b1;
                    rs_d       = i_rs;
                    poll_d     = i_poll & ~i_rs;
                    timeout_d  = 1'b0;
                    poll_cnt_d = '0;
                end
            end
            S_SETUP: begin
                if (cnt_q == AS_LAST) begin
                    cnt_d   = '0;
                    state_d = S_E_HIGH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_E_HIGH: begin
                if (cnt_q == PW_LAST) begin
                    cnt_d   = '0;
                    state_d = S_HOLD;
                    q_d     = d_smp;
                    if (!rs_q) begin
                        bf_d = d_smp[7];
                        ac_d = d_smp[6:0];
                    end else begin
                        bf_d = 1'b0;
                    end
                    if (poll_cnt_q != 16'hFFFF) begin
                        poll_cnt_d = poll_cnt_q + 16'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == H_LAST) begin
                    cnt_d   = '0;
                    state_d = S_RECOVER;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RECOVER: begin
                if (cnt_q == REC_LAST) begin
                    cnt_d = '0;
                    if (poll_q && bf_q && poll_cnt_q < POLL_LIM) begin
                        state_d = S_SETUP;
                    end else begin
                        valid_d   = 1'b1;
                        timeout_d = poll_q & bf_q;
                        state_d   = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = pend_d | (state_d != S_IDLE);
        e_d    = (state_d == S_E_HIGH);
        rw_d   = (state_d == S_SETUP) | e_d | (state_d == S_HOLD);
        rso_d  = rw_d & rs_d;
        oe_d   = ~rw_d;
    end

    // State and output registers; i_ena low freezes everything
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            poll_cnt_q <= '0;
            pend_q     <= 1'b0;
            rs_q       <= 1'b0;
            poll_q     <= 1'b0;
            q_q        <= '0;
            bf_q       <= 1'b0;
            ac_q       <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
            e_q        <= 1'b0;
            rw_q       <= 1'b0;
            rso_q      <= 1'b0;
            oe_q       <= 1'b1;
        end else if (i_ena) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            poll_cnt_q <= poll_cnt_d;
            pend_q     <= pend_d;
            rs_q       <= rs_d;
            poll_q     <= poll_d;
            q_q        <= q_d;
            bf_q       <= bf_d;
            ac_q       <= ac_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
            busy_q     <= busy_d;
            e_q        <= e_d;
            rw_q       <= rw_d;
            rso_q      <= rso_d;
            oe_q       <= oe_d;
        end
    end

    assign o_rs      = rso_q;
    assign o_rw      = rw_q;
    assign o_e       = e_q;
    assign o_d_oe    = oe_q;
    assign o_q       = q_q;
    assign o_bf      = bf_q;
    assign o_ac      = ac_q;
    assign o_valid   = valid_q;
    assign o_busy    = busy_q;
    assign o_timeout = timeout_q;

endmodule
